// File: rtl/serial_sub.sv
// serial_sub: bit-serial subtractor, D = A - B - Bin, LSB first, one bit per clock.
// Operands and the initial borrow are captured on an accepted start. The
// difference bits are shifted into D from the MSB side, so after WIDTH RUN
// edges D holds the full result with its LSB in D[0].
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   start        request, accepted only while not running (IDLE or DONE)
//   A, B, Bin    minuend, subtrahend and initial borrow, captured on accept
//   busy         high while bits are being processed
//   done         one-cycle pulse, D/Bout valid
//   D, Bout      registered difference and final borrow, held until next accept
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             a, b, d_bit, br_next, accept, last;

  // 1-bit subtract cell on the current LSBs
  assign a       = a_sr[0];
  assign b       = b_sr[0];
  assign d_bit   = a ^ b ^ br;
  assign br_next = (~a & b) | (~(a ^ b) & br);

  // start is honoured in DONE too, which gives back-to-back operation
  assign accept = start && (state != RUN);
  assign last   = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last)  state_n = DONE;
      DONE:    state_n = start ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr <= '0;
      b_sr <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      D    <= '0;
      Bout <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_sr <= A;
        b_sr <= B;
        br   <= Bin;
        cnt  <= '0;
        busy <= 1'b1;
        D    <= '0;
      end else if (state == RUN) begin
        D    <= {d_bit, D[WIDTH-1:1]};
        a_sr <= a_sr >> 1;
        b_sr <= b_sr >> 1;
        br   <= br_next;
        if (last) begin
          busy <= 1'b0;
          done <= 1'b1;
          Bout <= br_next;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
module tb_serial_sub;
  logic       clk = 1'b0;
  logic       rst;
  logic       start8, bin8, busy8, done8, bout8;
  logic [7:0] a8, b8, d8;
  logic       start4, bin4, busy4, done4, bout4;
  logic [3:0] a4, b4, d4;

  always #5 clk = ~clk;

  serial_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .Bin(bin8),
    .busy(busy8), .done(done8), .D(d8), .Bout(bout8)
  );

  serial_sub #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4), .Bin(bin4),
    .busy(busy4), .done(done4), .D(d4), .Bout(bout4)
  );

  typedef struct {
    logic [7:0] d;
    logic       bout;
  } exp_t;

  exp_t sb8[$];
  exp_t sb4[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: 9-bit unsigned difference; bit 8 set iff the result went negative.
  function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b,
                                 input logic bin);
    logic [8:0] r;
    exp_t       e;
    r      = {1'b0, a} - {1'b0, b} - 9'(bin);
    e.bout = r[8];
    e.d    = (w == 4) ? {4'h0, r[3:0]} : r[7:0];
    return e;
  endfunction

  // One WIDTH=8 operation with timing checks; optionally pulses start mid-run.
  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic bin, input bit inject);
    int   cyc;
    int   busy_cyc;
    exp_t e;
    @(negedge clk);
    a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
    sb8.push_back(model(8, a, b, bin));
    cyc = 0; busy_cyc = 0;
    while (cyc < 30) begin
      @(negedge clk);
      cyc++;
      start8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      if (inject && cyc == 4) start8 = 1'b1;
      if (busy8) busy_cyc++;
      if (done8) break;
    end
    check({tag, "_done_seen"}, done8, 1);
    e = sb8.pop_front();
    check({tag, "_D"}, d8, e.d);
    check({tag, "_Bout"}, bout8, e.bout);
    check({tag, "_latency"}, cyc, 9);
    check({tag, "_busy_cycles"}, busy_cyc, 8);
    @(negedge clk);
    check({tag, "_done_pulse"}, done8, 0);
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bin);
    int   cyc;
    exp_t e;
    @(negedge clk);
    a4 = a; b4 = b; bin4 = bin; start4 = 1'b1;
    sb4.push_back(model(4, {4'h0, a}, {4'h0, b}, bin));
    cyc = 0;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      start4 = 1'b0;
      if (done4) break;
    end
    e = sb4.pop_front();
    check("w4_done_seen", done4, 1);
    check("w4_D", {28'h0, d4}, {24'h0, e.d});
    check("w4_Bout", bout4, e.bout);
  endtask

  initial begin
    int   cyc;
    bit   saw_done;
    exp_t e;
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_D", d8, 0);
    check("rst_Bout", bout8, 0);
    rst = 1'b0;

    op8("t1", 8'h35, 8'h12, 1'b0, 1'b0);
    op8("t2", 8'h12, 8'h35, 1'b0, 1'b0);
    op8("t3a", 8'h00, 8'h00, 1'b1, 1'b0);

    // Reset during RUN cycle 3 (Bout is 1 from the previous op)
    @(negedge clk);
    a8 = 8'h35; b8 = 8'h12; bin8 = 1'b0; start8 = 1'b1;
    repeat (3) begin
      @(negedge clk);
      start8 = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_busy", busy8, 0);
    check("t5_done", done8, 0);
    check("t5_D", d8, 0);
    check("t5_Bout", bout8, 0);
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done8) saw_done = 1'b1;
    end
    check("t5_no_done", saw_done, 0);
    op8("t5_fresh", 8'hA0, 8'h0F, 1'b1, 1'b0);

    op8("t3b", 8'hFF, 8'hFF, 1'b0, 1'b0);
    op8("t4_ignored_start", 8'h35, 8'h12, 1'b0, 1'b1);

    // start held through done: second op launches in the DONE cycle
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    sb8.push_back(model(8, 8'h80, 8'h01, 1'b0));
    cyc = 0;
    while (cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (done8) break;
    end
    e = sb8.pop_front();
    check("t6_first_latency", cyc, 9);
    check("t6_first_D", d8, e.d);
    check("t6_first_Bout", bout8, e.bout);
    a8 = 8'h05; b8 = 8'h07; bin8 = 1'b1;
    sb8.push_back(model(8, 8'h05, 8'h07, 1'b1));
    cyc = 0;
    while (cyc < 30) begin
      @(negedge clk);
      cyc++;
      start8 = 1'b0;
      if (done8) break;
    end
    e = sb8.pop_front();
    check("t6_period", cyc, 9);
    check("t6_second_D", d8, e.d);
    check("t6_second_Bout", bout8, e.bout);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int bin = 0; bin < 2; bin++)
          op4(4'(a), 4'(b), 1'(bin));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
